// File: rtl/pwm_capture_multi.sv
// pwm_capture_multi
//   Multi-channel PWM period/duty capture. Each channel synchronises its raw
//   PWM input, measures the high and low phase lengths (in clk cycles) of
//   every complete period, and publishes them with a one-cycle valid strobe.
//   A phase that lasts longer than TIMEOUT cycles sets a sticky stuck flag.
//
// Ports
//   clk         rising-edge clock for all logic
//   reset       asynchronous, active-high; clears all state
//   enable      global enable; 0 parks every channel in IDLE
//   pwm_in      raw PWM inputs, asynchronous to clk, one bit per channel
//   high_count  channel c at [c*CNT_W +: CNT_W]; high phase of last period
//   low_count   same packing; low phase of last period
//   valid       one-cycle pulse when channel c updates its counts
//   stuck       channel c exceeded TIMEOUT in a single phase
module pwm_capture_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       pwm_in,
  output logic [CHANNELS*CNT_W-1:0] high_count,
  output logic [CHANNELS*CNT_W-1:0] low_count,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       stuck
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MEAS_HIGH = 2'd1;
  localparam logic [1:0] MEAS_LOW  = 2'd2;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic [1:0]             state;
    logic [CNT_W-1:0]       hr;
    logic [CNT_W-1:0]       lr;
    logic [CNT_W-1:0]       hc;
    logic [CNT_W-1:0]       lc;
    logic                   vld;
    logic                   stk;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Synchroniser keeps running regardless of enable.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync <= '0;
        s_d  <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], pwm_in[c]};
        s_d  <= s;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        hr    <= '0;
        lr    <= '0;
        hc    <= '0;
        lc    <= '0;
        vld   <= 1'b0;
        stk   <= 1'b0;
      end else begin
        vld <= 1'b0;
        if (!enable) begin
          state <= IDLE;
          hr    <= '0;
          lr    <= '0;
          stk   <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              // First edge only arms the measurement; no report yet.
              if (rise) begin
                state <= MEAS_HIGH;
                hr    <= ONE;
                lr    <= '0;
                stk   <= 1'b0;
              end
            end
            MEAS_HIGH: begin
              if (fall) begin
                state <= MEAS_LOW;
                lr    <= ONE;
              end else if (s) begin
                if (hr < TO_CNT) begin
                  hr <= hr + ONE;
                end else begin
                  state <= IDLE;
                  stk   <= 1'b1;
                end
              end
            end
            MEAS_LOW: begin
              if (rise) begin
                hc    <= hr;
                lc    <= lr;
                vld   <= 1'b1;
                hr    <= ONE;
                lr    <= '0;
                state <= MEAS_HIGH;
              end else if (!s) begin
                if (lr < TO_CNT) begin
                  lr <= lr + ONE;
                end else begin
                  state <= IDLE;
                  stk   <= 1'b1;
                end
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end

    assign high_count[c*CNT_W +: CNT_W] = hc;
    assign low_count[c*CNT_W +: CNT_W]  = lc;
    assign valid[c]                     = vld;
    assign stuck[c]                     = stk;
  end

endmodule

// File: tb/tb_pwm_capture_multi.sv
// tb_pwm_capture_multi
//   Directed bench for pwm_capture_multi (4 channels, 32-bit counts,
//   2 sync stages, TIMEOUT=16). Per-channel waveform generators drive pwm_in
//   one cycle at a time; tick numbers t count clock edges from the start of
//   each scenario, with the first generated high level sampled at edge 1.
module tb_pwm_capture_multi;

  localparam int CH = 4;
  localparam int W  = 32;
  localparam int SS = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [CH-1:0]   pwm_in;
  logic [CH*W-1:0] high_count;
  logic [CH*W-1:0] low_count;
  logic [CH-1:0]   valid;
  logic [CH-1:0]   stuck;

  pwm_capture_multi #(
    .CHANNELS(CH),
    .CNT_W(W),
    .SYNC_STAGES(SS),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pwm_in(pwm_in),
    .high_count(high_count),
    .low_count(low_count),
    .valid(valid),
    .stuck(stuck)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int t      = 0;

  int   gen_h   [CH];
  int   gen_l   [CH];
  int   gen_cnt [CH];
  bit   gen_on  [CH];
  logic stat    [CH];
  int   nvalid  [CH];
  int   first_t [CH];
  int   last_t  [CH];
  int   exp_h   [CH];
  int   exp_l   [CH];
  int   exp_per [CH];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] gen_drive();
    logic [CH-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++)
      v[c] = gen_on[c] ? (gen_cnt[c] < gen_h[c]) : stat[c];
    return v;
  endfunction

  // One clock edge: sample outputs, then advance generators for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    for (int c = 0; c < CH; c++) begin
      if (valid[c]) begin
        nvalid[c]++;
        if (first_t[c] < 0) first_t[c] = t;
        chk($sformatf("hc%0d_t%0d", c, t), high_count[c*W +: W], exp_h[c]);
        chk($sformatf("lc%0d_t%0d", c, t), low_count[c*W +: W], exp_l[c]);
        if (exp_per[c] > 0 && last_t[c] >= 0)
          chk($sformatf("per%0d_t%0d", c, t), t - last_t[c], exp_per[c]);
        last_t[c] = t;
      end
    end
    for (int c = 0; c < CH; c++)
      if (gen_on[c]) gen_cnt[c] = (gen_cnt[c] + 1) % (gen_h[c] + gen_l[c]);
    pwm_in = gen_drive();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_gen(input int c, input int h, input int l, input int per);
    gen_on[c]  = 1'b1;
    gen_h[c]   = h;
    gen_l[c]   = l;
    gen_cnt[c] = 0;
    exp_h[c]   = h;
    exp_l[c]   = l;
    exp_per[c] = per;
    pwm_in     = gen_drive();
  endtask

  task automatic clear_stats();
    t = 0;
    for (int c = 0; c < CH; c++) begin
      nvalid[c]  = 0;
      first_t[c] = -1;
      last_t[c]  = -1;
    end
  endtask

  task automatic all_static(input logic v);
    for (int c = 0; c < CH; c++) begin
      gen_on[c] = 1'b0;
      stat[c]   = v;
      exp_per[c] = 0;
    end
    pwm_in = gen_drive();
  endtask

  task automatic do_reset();
    all_static(1'b0);
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;
    clear_stats();
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < CH; c++) begin
      gen_h[c] = 1; gen_l[c] = 1; gen_cnt[c] = 0; exp_h[c] = 0; exp_l[c] = 0;
    end
    all_static(1'b0);
    clear_stats();
    ticks(2);
    chk("rst_high", high_count, 0);
    chk("rst_low", low_count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_stuck", stuck, 0);
    reset = 1'b0;
    clear_stats();

    // Ch0 3/5: rises at edges 1,9,17,...; reports at 11,19,27,35.
    start_gen(0, 3, 5, 8);
    ticks(40);
    chk("t1_nvalid", nvalid[0], 4);
    chk("t1_first", first_t[0], 11);
    chk("t1_last", last_t[0], 35);

    // Ch0 3/5 and ch1 10/2 together; ch2/ch3 idle at 0.
    do_reset();
    start_gen(0, 3, 5, 8);
    start_gen(1, 10, 2, 12);
    ticks(50);
    chk("t2_nv0", nvalid[0], 5);
    chk("t2_first0", first_t[0], 11);
    chk("t2_nv1", nvalid[1], 3);
    chk("t2_first1", first_t[1], 15);
    chk("t2_nv2", nvalid[2], 0);
    chk("t2_nv3", nvalid[3], 0);
    chk("t2_hc2", high_count[2*W +: W], 0);
    chk("t2_lc3", low_count[3*W +: W], 0);

    // Ch0 1/1: rises every 2 edges from 1; reports at 5,7,...,19.
    do_reset();
    start_gen(0, 1, 1, 2);
    ticks(20);
    chk("t3_nvalid", nvalid[0], 8);
    chk("t3_first", first_t[0], 5);

    // Timeout: two 4/4 periods, then held high from edge 17.
    do_reset();
    start_gen(0, 4, 4, 0);
    ticks(16);
    gen_on[0] = 1'b0;
    stat[0]   = 1'b1;
    pwm_in    = gen_drive();
    ticks(18);                               // t = 34
    chk("t4_nv_pre", nvalid[0], 2);
    chk("t4_first", first_t[0], 11);
    chk("t4_stuck_pre", stuck[0], 1'b0);
    tick();                                  // t = 35
    chk("t4_stuck_set", stuck[0], 1'b1);
    chk("t4_hc_hold", high_count[0 +: W], 4);
    chk("t4_lc_hold", low_count[0 +: W], 4);
    ticks(5);                                // t = 40
    chk("t4_stuck_sticky", stuck[0], 1'b1);
    start_gen(0, 4, 4, 0);                   // high continues; next rise at 49
    ticks(10);                               // t = 50
    chk("t4_stuck_before_rise", stuck[0], 1'b1);
    tick();                                  // t = 51
    chk("t4_stuck_cleared", stuck[0], 1'b0);
    ticks(7);                                // t = 58
    chk("t4_nv_no_rise_valid", nvalid[0], 2);
    tick();                                  // t = 59
    chk("t4_nv_after", nvalid[0], 3);
    chk("t4_last", last_t[0], 59);

    // Asynchronous reset mid-period after a report.
    ticks(3);                                // t = 62
    chk("t5_hc_before", high_count[0 +: W], 4);
    reset = 1'b1;
    #1;
    chk("t5_rst_high", high_count, 0);
    chk("t5_rst_low", low_count, 0);
    chk("t5_rst_valid", valid, 0);
    chk("t5_rst_stuck", stuck, 0);
    all_static(1'b0);
    ticks(2);
    reset = 1'b0;
    clear_stats();
    start_gen(0, 4, 4, 8);
    ticks(20);
    chk("t5_first", first_t[0], 11);
    chk("t5_nvalid", nvalid[0], 2);

    // enable=0 for edges 21..30 on a 3/5 input.
    do_reset();
    start_gen(0, 3, 5, 8);
    ticks(20);
    chk("t6_nv_pre", nvalid[0], 2);
    exp_per[0] = 0;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t6_valid_t%0d", t), valid, 0);
      chk($sformatf("t6_stuck_t%0d", t), stuck, 0);
    end
    chk("t6_hc_hold", high_count[0 +: W], 3);
    chk("t6_lc_hold", low_count[0 +: W], 5);
    enable = 1'b1;
    ticks(12);                               // t = 42
    chk("t6_nv_mid", nvalid[0], 2);
    tick();                                  // t = 43
    chk("t6_nv_post", nvalid[0], 3);
    chk("t6_last", last_t[0], 43);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture_multi.md
# pwm_capture_multi

Multi-channel, parametrised PWM period/duty capture block. It is the successor to the single-channel PWM detector. Each channel synchronises an asynchronous PWM input and measures the high-phase and low-phase length of every complete period in clk cycles. It publishes the result with a one-cycle valid strobe and flags inputs stuck at one level for longer than a programmable timeout. It sits between the board-level PWM pins and the register/bus interface that reads duty and period.

## Interface
- CHANNELS, 4, number of independent PWM inputs (1..32)
- CNT_W, 32, width of each count output (8..32)
- SYNC_STAGES, 2, synchroniser flops per input (2..4)
- TIMEOUT, 1000000, maximum phase length in cycles before stuck is flagged; must be <= 2^CNT_W-1

- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- enable  input  1  global enable; 0 holds all channels in IDLE
- pwm_in  input  CHANNELS  raw PWM inputs, asynchronous to clk
- high_count  output  CHANNELS*CNT_W  channel c at [c*CNT_W +: CNT_W]; high-phase length of last complete period
- low_count  output  CHANNELS*CNT_W  same packing; low-phase length of last complete period
- valid  output  CHANNELS  one-cycle pulse when channel c updates its counts
- stuck  output  CHANNELS  channel c has exceeded TIMEOUT in one phase

## Operation
- Per channel: a SYNC_STAGES flop chain produces s, and s_d is s delayed by one cycle. Rise = s & ~s_d. Fall = ~s & s_d. All flops reset to 0.
- Run counters hr and lr are CNT_W wide and reset to 0.
- The per-channel FSM has three states: IDLE, MEAS_HIGH and MEAS_LOW. Reset state is IDLE.
- IDLE:
  - On Rise: go to MEAS_HIGH, set hr=1 and lr=0, clear stuck. No valid is produced.
  - Fall is ignored. Counters hold.
- MEAS_HIGH:
  - If s=1 and hr<TIMEOUT: increment hr.
  - If s=1 and hr==TIMEOUT: go to IDLE and set stuck=1.
  - On Fall: go to MEAS_LOW and set lr=1.
- MEAS_LOW:
  - If s=0 and lr<TIMEOUT: increment lr.
  - If s=0 and lr==TIMEOUT: go to IDLE and set stuck=1.
  - On Rise: latch high_count=hr and low_count=lr, pulse valid, set hr=1 and lr=0, go to MEAS_HIGH.
- A period of H cycles high followed by L cycles low on s reports high_count=H and low_count=L. The minimum reportable phase is 1 cycle.
- Counters never wrap. They stop at TIMEOUT and the timeout path is taken.
- stuck is sticky until the next Rise or until enable=0. high_count and low_count hold their last values while stuck is set.
- enable=0 forces, every cycle and on all channels:
  - state=IDLE, hr=lr=0, stuck=0, valid=0.
  - high_count and low_count hold.
  - The synchronisers keep running.
- Channels are fully independent. Simultaneous events on different channels are all processed in the same cycle.

## Timing
- Reset values: high_count=0, low_count=0, valid=0, stuck=0, all FSMs in IDLE.
- Reset mid-operation discards any partial period. The first Rise after reset is never reported.
- Latency:
  - Counting the first clk edge that samples pwm_in[c] high as edge 1, valid[c], high_count and low_count update at edge SYNC_STAGES+1.
  - stuck has the same pipeline offset.
- valid is exactly one cycle wide. The maximum rate is one pulse per 2 cycles per channel.
- There is no backpressure. The consumer must sample counts while valid is high or before the next valid.
- Input pulses shorter than one clk period may be missed. This is accepted behaviour.

## Test plan
- Ch0 repeats 3 cycles high / 5 cycles low, synchronous to clk -> no valid on the first Rise. Then every 8 cycles, valid[0]=1 with high_count[0]=3 and low_count[0]=5.
- Ch0 at 3/5 and ch1 at 10/2 concurrently, ch2 and ch3 held 0 -> each channel reports its own values at its own cadence. Ch2 and ch3 valid stay 0 and their counts stay 0.
- Ch0 alternating 1 high / 1 low -> valid every 2 cycles with high_count=1 and low_count=1.
- TIMEOUT=16, ch0 held high after a Rise -> stuck[0]=1 at the end of the 17th high cycle of s, with counts unchanged. A later 4/4 waveform gives: next Rise clears stuck, no valid at that Rise, then valid with 4/4 one period later.
- reset asserted mid-period after at least one report -> all outputs 0 immediately. After release, the first valid appears only after two Rises.
- enable=0 for 10 cycles mid-period with a 3/5 input -> valid=0 and stuck=0, counts hold. After enable=1, the first valid appears at the second Rise.
